cla_adder_pipe: RTL

//  Parametrised, pipelined carry-lookahead add/subtract unit built from GROUP-bit lookahead blocks.
//  - Within a group: full generate/propagate lookahead. Between groups inside a stage: rippled group carries.
//  - Between stages: registered carry.
//  - Supports ADD/SUB/ADC/SBB, produces carry/overflow/zero flags, uses a valid/ready handshake.
//  - Serves the EX stage and multi-cycle datapaths where a full-width single-cycle carry chain misses timing.

---
 rtl/cla_adder_pipe.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead add/subtract unit.
// The input operands are captured in an input register. Each of STAGES
// pipeline stages then resolves one WIDTH/STAGES-bit slice of the result
// from the registered operands and the carry registered by the stage before.
// Inside a slice, GROUP-bit lookahead blocks are chained by rippled group
// carries. All registers, including bubbles, advance together under a
// single global stall.
module cla_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int CPG = WIDTH / (GROUP * STAGES);  // lookahead groups per stage
    localparam int SW  = CPG * GROUP;                // result bits per stage

    // Result of one lookahead group, packed as {carry into MSB, carry out, sum}.
    // Every carry is written as a flat sum of products, so it does not ripple.
    function automatic logic [GROUP+1:0] cla_group(
        input logic [GROUP-1:0] x,
        input logic [GROUP-1:0] y,
        input logic             ci
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic [GROUP-1:0] s;
        logic             term;
        g    = x & y;
        p    = x | y;
        c    = '0;
        c[0] = ci;
        for (int j = 0; j < GROUP; j++) begin
            c[j+1] = g[j];
            for (int k = 0; k < j; k++) begin
                term = g[k];
                for (int m = k + 1; m <= j; m++) begin
                    term = term & p[m];
                end
                c[j+1] = c[j+1] | term;
            end
            term = ci;
            for (int m = 0; m <= j; m++) begin
                term = term & p[m];
            end
            c[j+1] = c[j+1] | term;
        end
        s = (p & ~g) ^ c[GROUP-1:0];
        return {c[GROUP-1], c[GROUP], s};
    endfunction

    // Operand preparation.
    logic [WIDTH-1:0] b_prep_s;
    logic             c0_s;

    // Input register.
    logic             in_vld_r;
    logic [WIDTH-1:0] in_a_r;
    logic [WIDTH-1:0] in_b_r;
    logic             in_c_r;

    // Stage registers.
    // Operand slices are carried along for the later stages, and the result
    // slices already resolved are carried along to line them up with the
    // upper slices.
    logic             stg_vld_r [STAGES];
    logic [WIDTH-1:0] stg_a_r   [STAGES];
    logic [WIDTH-1:0] stg_b_r   [STAGES];
    logic [WIDTH-1:0] stg_sum_r [STAGES];
    logic             stg_c_r   [STAGES];
    logic             ovf_r;
    logic             zero_r;

    // What each stage sees on its input side, and what it computes.
    logic             src_vld_s [STAGES];
    logic [WIDTH-1:0] src_a_s   [STAGES];
    logic [WIDTH-1:0] src_b_s   [STAGES];
    logic [WIDTH-1:0] src_sum_s [STAGES];
    logic             src_c_s   [STAGES];
    logic [WIDTH-1:0] nxt_sum_s [STAGES];
    logic             nxt_c_s   [STAGES];
    logic             msb_c_s;
    logic             advance_s;

    // Invert B for subtracting ops and pick the effective carry-in.
    always_comb begin
        b_prep_s = op[0] ? ~b : b;
        c0_s     = 1'b0;
        case (op)
            2'b00:   c0_s = 1'b0;
            2'b01:   c0_s = 1'b1;
            2'b10:   c0_s = cin;
            2'b11:   c0_s = ~cin;
            default: c0_s = 1'b0;
        endcase
    end

    // Feed each stage from the input register (stage 0) or from the stage
    // register before it.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            int prev;
            prev = (s == 0) ? 0 : s - 1;
            if (s == 0) begin
                src_vld_s[s] = in_vld_r;
                src_a_s[s]   = in_a_r;
                src_b_s[s]   = in_b_r;
                src_sum_s[s] = '0;
                src_c_s[s]   = in_c_r;
            end else begin
                src_vld_s[s] = stg_vld_r[prev];
                src_a_s[s]   = stg_a_r[prev];
                src_b_s[s]   = stg_b_r[prev];
                src_sum_s[s] = stg_sum_r[prev];
                src_c_s[s]   = stg_c_r[prev];
            end
        end
    end

    // Resolve one slice per stage, rippling the group carries across it.
    always_comb begin
        msb_c_s = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            logic             carry;
            logic [GROUP+1:0] r;
            int               idx;
            nxt_sum_s[s] = src_sum_s[s];
            carry        = src_c_s[s];
            for (int g = 0; g < CPG; g++) begin
                idx = s * SW + g * GROUP;
                r   = cla_group(src_a_s[s][idx +: GROUP], src_b_s[s][idx +: GROUP], carry);
                nxt_sum_s[s][idx +: GROUP] = r[GROUP-1:0];
                carry = r[GROUP];
                if ((s == STAGES - 1) && (g == CPG - 1)) begin
                    msb_c_s = r[GROUP+1];
                end else begin
                    msb_c_s = msb_c_s;
                end
            end
            nxt_c_s[s] = carry;
        end
    end

    assign out_valid = stg_vld_r[STAGES-1];
    assign in_ready  = ~out_valid | out_ready;
    assign advance_s = in_ready;
    assign sum       = stg_sum_r[STAGES-1];
    assign co        = stg_c_r[STAGES-1];
    assign ovf       = ovf_r;
    assign zero      = zero_r;

    // Pipeline advance under the global stall. The output slot loads only
    // when a valid operation reaches it, so a bubble leaves the last result
    // and its flags in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_vld_r <= 1'b0;
            in_a_r   <= '0;
            in_b_r   <= '0;
            in_c_r   <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                stg_vld_r[s] <= 1'b0;
                stg_a_r[s]   <= '0;
                stg_b_r[s]   <= '0;
                stg_sum_r[s] <= '0;
                stg_c_r[s]   <= 1'b0;
            end
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (advance_s) begin
            in_vld_r <= in_valid;
            in_a_r   <= a;
            in_b_r   <= b_prep_s;
            in_c_r   <= c0_s;
            for (int s = 0; s < STAGES; s++) begin
                stg_vld_r[s] <= src_vld_s[s];
                stg_a_r[s]   <= src_a_s[s];
                stg_b_r[s]   <= src_b_s[s];
                if ((s != STAGES - 1) || src_vld_s[s]) begin
                    stg_sum_r[s] <= nxt_sum_s[s];
                    stg_c_r[s]   <= nxt_c_s[s];
                end
            end
            if (src_vld_s[STAGES-1]) begin
                ovf_r  <= msb_c_s ^ nxt_c_s[STAGES-1];
                zero_r <= ~|nxt_sum_s[STAGES-1];
            end
        end
    end

endmodule
